// File: rtl/common_fifo_pkg.sv
// Shared FIFO helpers: pointer/depth sizing and the full/empty pointer compare.
// Used by common_dffram_fifo and its storage sub-module.
package common_fifo_pkg;

    localparam int FIFO_ADDR_WIDTH_MAX = 6;
    localparam int FIFO_PTR_WIDTH_MAX  = FIFO_ADDR_WIDTH_MAX + 1;

    typedef logic [FIFO_PTR_WIDTH_MAX-1:0] fifo_ptr_t;

    typedef struct packed {
        logic full;
        logic empty;
    } fifo_ptr_status_t;

    function automatic int FIFO_PTR_WIDTH(input int addr);
        return addr + 1;
    endfunction

    function automatic int FIFO_DEPTH(input int addr);
        return 1 << addr;
    endfunction

    // Pointers arrive zero-extended to the widest legal size, so bit addr_width is the wrap bit.
    function automatic fifo_ptr_status_t fifo_ptr_compare(
        input fifo_ptr_t wptr,
        input fifo_ptr_t rptr,
        input int        addr_width
    );
        fifo_ptr_t        diff;
        fifo_ptr_t        low_mask;
        fifo_ptr_status_t st;
        diff     = wptr ^ rptr;
        low_mask = fifo_ptr_t'((1 << addr_width) - 1);
        st.empty = (diff == '0);
        st.full  = ((diff & low_mask) == '0) && ((diff >> addr_width) == fifo_ptr_t'(1));
        return st;
    endfunction

endpackage

// File: rtl/common_dffram_2a1w1r.sv
// Flip-flop RAM: port A write-only (synchronous), port B read-only (combinational).
// Active-high synchronous reset clears every word.
module common_dffram_2a1w1r
    import common_fifo_pkg::*;
#(
    parameter int RAM_DATA_WIDTH = 8,
    parameter int RAM_ADDR_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic                      wea,
    input  logic [RAM_ADDR_WIDTH-1:0] addra,
    input  logic [RAM_DATA_WIDTH-1:0] dina,
    input  logic [RAM_ADDR_WIDTH-1:0] addrb,
    output logic [RAM_DATA_WIDTH-1:0] doutb
);

    localparam int DEPTH = FIFO_DEPTH(RAM_ADDR_WIDTH);

    logic [RAM_DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the whole array is reset because this RAM is built from flops and
    // consumers rely on out_data reading zero after reset; an SRAM macro could not do this.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (ena && wea) begin
            mem[addra] <= dina;
        end
    end

    assign doutb = mem[addrb];

endmodule

// File: rtl/common_dffram_fifo.sv
// Single-clock valid/ready FIFO on common_dffram_2a1w1r; no fall-through.
// Define COMMON_DFFRAM_FIFO_STATUS_EN to add the registered count and the afull flag.
module common_dffram_fifo
    import common_fifo_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH  = 8,
    parameter int FIFO_ADDR_WIDTH  = 2,
    parameter int FIFO_AFULL_LEVEL = FIFO_DEPTH(FIFO_ADDR_WIDTH) - 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [FIFO_DATA_WIDTH-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
`ifdef COMMON_DFFRAM_FIFO_STATUS_EN
    output logic [FIFO_ADDR_WIDTH:0]   count,
    output logic                       afull,
`endif
    output logic [FIFO_DATA_WIDTH-1:0] out_data
);

    localparam int PTR_W = FIFO_PTR_WIDTH(FIFO_ADDR_WIDTH);

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    fifo_ptr_status_t ptr_st;
    logic             push;
    logic             pop;
    logic             ram_we;

    always_comb begin
        ptr_st = fifo_ptr_compare(fifo_ptr_t'(wptr), fifo_ptr_t'(rptr), FIFO_ADDR_WIDTH);
    end

    // Handshake outputs come from pointer state only, never from in_valid/out_ready.
    assign in_ready  = !ptr_st.full;
    assign out_valid = !ptr_st.empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    // A flushed push must not reach the RAM; flush leaves stored words as they were.
    assign ram_we    = push && !flush;

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
        end
    end

    common_dffram_2a1w1r #(
        .RAM_DATA_WIDTH (FIFO_DATA_WIDTH),
        .RAM_ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (!resetn),
        .ena   (ram_we),
        .wea   (ram_we),
        .addra (wptr[FIFO_ADDR_WIDTH-1:0]),
        .dina  (in_data),
        .addrb (rptr[FIFO_ADDR_WIDTH-1:0]),
        .doutb (out_data)
    );

`ifdef COMMON_DFFRAM_FIFO_STATUS_EN
    localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(FIFO_AFULL_LEVEL);

    // Tracks wptr - rptr incrementally so the output path never sees a subtractor.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + PTR_W'(1);
                2'b01:   count <= count - PTR_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign afull = (count >= AFULL_LVL);
`else
    // Status build disabled: occupancy is only implied by in_ready/out_valid.
`endif

endmodule
